// File: rtl/didactic_status_ctrl.sv
// End-of-computation status block: exit code, run-cycle counter,
// watchdog and scratch register on an APB3 slave port.
module didactic_status_ctrl #(
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter logic [31:0] WDT_DEFAULT = 32'h0000_0000,
    parameter logic [30:0] WDT_CODE    = 31'h0000_DEAD
) (
    input  logic                  clk_in,
    input  logic                  reset,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]           PWDATA,
    output logic [31:0]           PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    input  logic                  count_en_i,
    output logic                  eoc_o,
    output logic                  eoc_pulse_o,
    output logic                  exit_fail_o
);

    localparam logic [7:0] OFF_STATUS  = 8'hA0;
    localparam logic [7:0] OFF_CYCLES  = 8'hA4;
    localparam logic [7:0] OFF_WDT     = 8'hA8;
    localparam logic [7:0] OFF_SCRATCH = 8'hAC;

    logic [31:0] status_q, status_d;
    logic [31:0] cycles_q, cycles_d;
    logic [31:0] wdt_q, wdt_d;
    logic [31:0] scratch_q, scratch_d;
    logic        pulse_q, pulse_d;

    logic [7:0]  offs;
    logic        sel_status, sel_cycles;
    logic        sel_wdt, sel_scratch;
    logic        setup, access, wr_access;
    logic        eoc, expire, commit;
    logic [31:0] rd_data;
    logic        rd_err;

    // Upper address bits are not decoded.
    logic        unused_addr;
    assign unused_addr = ^PADDR[ADDR_WIDTH-1:8];

    assign offs        = PADDR[7:0];
    assign sel_status  = (offs == OFF_STATUS);
    assign sel_cycles  = (offs == OFF_CYCLES);
    assign sel_wdt     = (offs == OFF_WDT);
    assign sel_scratch = (offs == OFF_SCRATCH);

    assign setup     = PSEL & ~PENABLE;
    assign access    = PSEL & PENABLE;
    assign wr_access = access & PWRITE;

    assign eoc    = status_q[31];
    assign expire = (wdt_q != 32'd0) & ~eoc
                  & (cycles_q == wdt_q);
    assign commit = wr_access & sel_status & ~eoc;

    // Read mux and error decode, captured at the setup edge.
    // A STATUS write is refused if EOC is set or about to be
    // set by the watchdog on the same edge.
    always_comb begin
        rd_data = 32'd0;
        rd_err  = 1'b0;
        unique case (1'b1)
            sel_status: begin
                rd_data = status_q;
                rd_err  = PWRITE & (eoc | expire);
            end
            sel_cycles: begin
                rd_data = cycles_q;
                rd_err  = PWRITE;
            end
            sel_wdt: begin
                rd_data = wdt_q;
            end
            sel_scratch: begin
                rd_data = scratch_q;
            end
            default: begin
                rd_err = 1'b1;
            end
        endcase
        if (PWRITE) begin
            rd_data = 32'd0;
        end
    end

    // Next state of STATUS: software commit beats watchdog.
    always_comb begin
        status_d = status_q;
        if (commit) begin
            status_d = {1'b1, PWDATA[30:0]};
        end else if (expire) begin
            status_d = {1'b1, WDT_CODE};
        end
    end

    // Saturating run counter, frozen once EOC is reached or
    // being reached on this edge.
    always_comb begin
        cycles_d = cycles_q;
        if (count_en_i && !eoc && !commit &&
            !expire && (cycles_q != '1)) begin
            cycles_d = cycles_q + 32'd1;
        end
    end

    // Plain RW registers written at the access-phase edge.
    always_comb begin
        wdt_d     = wdt_q;
        scratch_d = scratch_q;
        if (wr_access && sel_wdt) begin
            wdt_d = PWDATA;
        end
        if (wr_access && sel_scratch) begin
            scratch_d = PWDATA;
        end
    end

    // One-cycle pulse on the 0->1 transition of EOC.
    always_comb begin
        pulse_d = ~eoc & status_d[31];
    end

    // State registers.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            status_q  <= 32'd0;
            cycles_q  <= 32'd0;
            wdt_q     <= WDT_DEFAULT;
            scratch_q <= 32'd0;
            pulse_q   <= 1'b0;
        end else begin
            status_q  <= status_d;
            cycles_q  <= cycles_d;
            wdt_q     <= wdt_d;
            scratch_q <= scratch_d;
            pulse_q   <= pulse_d;
        end
    end

    // APB response: load at setup, hold through access,
    // otherwise idle at zero.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            PRDATA  <= 32'd0;
            PSLVERR <= 1'b0;
        end else if (setup) begin
            PRDATA  <= rd_data;
            PSLVERR <= rd_err;
        end else if (!access) begin
            PRDATA  <= 32'd0;
            PSLVERR <= 1'b0;
        end
    end

    assign PREADY      = 1'b1;
    assign eoc_o       = eoc;
    assign eoc_pulse_o = pulse_q;
    assign exit_fail_o = eoc & (|status_q[30:0]);

endmodule

// File: tb/tb_didactic_status_ctrl.sv
// Self-checking bench for didactic_status_ctrl: vector table,
// scoreboard queue and hand-timed watchdog/reset sequences.
module tb_didactic_status_ctrl;

    logic        clk_in = 1'b0;
    logic        reset = 1'b0;
    logic        PSEL = 1'b0;
    logic        PENABLE = 1'b0;
    logic        PWRITE = 1'b0;
    logic [11:0] PADDR = 12'd0;
    logic [31:0] PWDATA = 32'd0;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic        count_en_i = 1'b0;
    logic        eoc_o;
    logic        eoc_pulse_o;
    logic        exit_fail_o;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] rd;
        logic        err;
        logic        chk;
    } exp_t;

    typedef struct {
        logic        wr;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic        err;
        logic        chk;
    } vec_t;

    exp_t sbq[$];
    vec_t vt[10];

    didactic_status_ctrl dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR),
        .count_en_i  (count_en_i),
        .eoc_o       (eoc_o),
        .eoc_pulse_o (eoc_pulse_o),
        .exit_fail_o (exit_fail_o)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string nm,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h",
                     nm, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the
    // access-phase edge.
    task automatic xfer(input string nm,
                        input logic wr,
                        input logic [11:0] a,
                        input logic [31:0] wd,
                        input logic [31:0] er,
                        input logic ee,
                        input logic ck);
        exp_t e;
        sbq.push_back({er, ee, ck});
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = wr;
        PADDR   = a;
        PWDATA  = wd;
        @(negedge clk_in);
        PENABLE = 1'b1;
        e = sbq.pop_front();
        if (e.chk) check({nm, ".rdata"}, PRDATA, e.rd);
        check({nm, ".slverr"}, {31'd0, PSLVERR},
              {31'd0, e.err});
        @(negedge clk_in);
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = 12'd0;
        PWDATA  = 32'd0;
    endtask

    task automatic do_reset();
        reset   = 1'b0;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        repeat (2) @(negedge clk_in);
        reset = 1'b1;
    endtask

    initial begin
        vt[0] = '{1'b0, 12'h0A0, 32'h0, 32'h0, 1'b0, 1'b1};
        vt[1] = '{1'b1, 12'h0AC, 32'hA5A5_5A5A, 32'h0,
                  1'b0, 1'b0};
        vt[2] = '{1'b0, 12'h0AC, 32'h0, 32'hA5A5_5A5A,
                  1'b0, 1'b1};
        vt[3] = '{1'b1, 12'h0A4, 32'h1234, 32'h0,
                  1'b1, 1'b0};
        vt[4] = '{1'b0, 12'h0A4, 32'h0, 32'd104, 1'b0, 1'b1};
        vt[5] = '{1'b0, 12'h010, 32'h0, 32'h0, 1'b1, 1'b1};
        vt[6] = '{1'b1, 12'h010, 32'hFFFF_FFFF, 32'h0,
                  1'b1, 1'b0};
        vt[7] = '{1'b0, 12'h0A8, 32'h0, 32'h0, 1'b0, 1'b1};
        vt[8] = '{1'b0, 12'h1A0, 32'h0, 32'h0, 1'b0, 1'b1};
        vt[9] = '{1'b0, 12'h0AC, 32'h0, 32'hA5A5_5A5A,
                  1'b0, 1'b1};

        // Reset and counting
        count_en_i = 1'b1;
        repeat (3) @(negedge clk_in);
        check("rst.prdata", PRDATA, 32'h0);
        check("rst.pslverr", {31'd0, PSLVERR}, 32'd0);
        check("rst.pready", {31'd0, PREADY}, 32'd1);
        check("rst.eoc", {31'd0, eoc_o}, 32'd0);
        check("rst.pulse", {31'd0, eoc_pulse_o}, 32'd0);
        check("rst.fail", {31'd0, exit_fail_o}, 32'd0);
        reset = 1'b1;
        repeat (100) @(negedge clk_in);
        xfer("cnt100", 1'b0, 12'h0A4, 0, 32'd100, 1'b0, 1'b1);
        xfer("st0", 1'b0, 12'h0A0, 0, 32'd0, 1'b0, 1'b1);
        count_en_i = 1'b0;
        check("cnt.eoc", {31'd0, eoc_o}, 32'd0);

        // Vector table with the counter parked at 104
        for (int i = 0; i < 10; i++) begin
            xfer($sformatf("vec%0d", i), vt[i].wr, vt[i].addr,
                 vt[i].wdata, vt[i].rd, vt[i].err, vt[i].chk);
        end

        // Pass exit
        count_en_i = 1'b1;
        xfer("pass.wr", 1'b1, 12'h0A0, 32'h8000_0000,
             0, 1'b0, 1'b0);
        check("pass.eoc", {31'd0, eoc_o}, 32'd1);
        check("pass.pulse", {31'd0, eoc_pulse_o}, 32'd1);
        check("pass.fail", {31'd0, exit_fail_o}, 32'd0);
        @(negedge clk_in);
        check("pass.pulse_end", {31'd0, eoc_pulse_o}, 32'd0);
        xfer("pass.cyc", 1'b0, 12'h0A4, 0, 32'd105, 1'b0, 1'b1);
        xfer("pass.st", 1'b0, 12'h0A0, 0, 32'h8000_0000,
             1'b0, 1'b1);
        xfer("pass.cyc2", 1'b0, 12'h0A4, 0, 32'd105, 1'b0, 1'b1);

        // Fail exit and write-once
        do_reset();
        xfer("fail.wr", 1'b1, 12'h0A0, 32'h0000_0005,
             0, 1'b0, 1'b0);
        check("fail.eoc", {31'd0, eoc_o}, 32'd1);
        check("fail.flag", {31'd0, exit_fail_o}, 32'd1);
        xfer("once.wr", 1'b1, 12'h0A0, 32'h0, 0, 1'b1, 1'b0);
        xfer("once.st", 1'b0, 12'h0A0, 0, 32'h8000_0005,
             1'b0, 1'b1);
        check("once.flag", {31'd0, exit_fail_o}, 32'd1);

        // Watchdog expiry
        count_en_i = 1'b0;
        do_reset();
        xfer("wdt.wr", 1'b1, 12'h0A8, 32'd50, 0, 1'b0, 1'b0);
        xfer("wdt.rd", 1'b0, 12'h0A8, 0, 32'd50, 1'b0, 1'b1);
        count_en_i = 1'b1;
        repeat (50) @(negedge clk_in);
        check("wdt.pre_eoc", {31'd0, eoc_o}, 32'd0);
        @(negedge clk_in);
        check("wdt.eoc", {31'd0, eoc_o}, 32'd1);
        check("wdt.pulse", {31'd0, eoc_pulse_o}, 32'd1);
        xfer("wdt.st", 1'b0, 12'h0A0, 0, 32'h8000_DEAD,
             1'b0, 1'b1);
        xfer("wdt.cyc", 1'b0, 12'h0A4, 0, 32'd50, 1'b0, 1'b1);
        check("wdt.fail", {31'd0, exit_fail_o}, 32'd1);

        // Software write on the expiry edge
        count_en_i = 1'b0;
        do_reset();
        xfer("col.lim", 1'b1, 12'h0A8, 32'd20, 0, 1'b0, 1'b0);
        count_en_i = 1'b1;
        repeat (19) @(negedge clk_in);
        xfer("col.wr", 1'b1, 12'h0A0, 32'h0000_0077,
             0, 1'b0, 1'b0);
        check("col.eoc", {31'd0, eoc_o}, 32'd1);
        xfer("col.st", 1'b0, 12'h0A0, 0, 32'h8000_0077,
             1'b0, 1'b1);
        xfer("col.cyc", 1'b0, 12'h0A4, 0, 32'd20, 1'b0, 1'b1);

        // Reset in the access phase of a STATUS write
        count_en_i = 1'b0;
        xfer("mid.scr", 1'b1, 12'h0AC, 32'h1234, 0, 1'b0, 1'b0);
        PSEL   = 1'b1;
        PWRITE = 1'b1;
        PADDR  = 12'h0A0;
        PWDATA = 32'h42;
        @(negedge clk_in);
        PENABLE = 1'b1;
        #2 reset = 1'b0;
        #1;
        check("mid.eoc", {31'd0, eoc_o}, 32'd0);
        check("mid.fail", {31'd0, exit_fail_o}, 32'd0);
        check("mid.prdata", PRDATA, 32'h0);
        @(negedge clk_in);
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        @(negedge clk_in);
        reset = 1'b1;
        @(negedge clk_in);
        xfer("mid.st", 1'b0, 12'h0A0, 0, 32'h0, 1'b0, 1'b1);
        xfer("mid.cyc", 1'b0, 12'h0A4, 0, 32'h0, 1'b0, 1'b1);
        xfer("mid.wdt", 1'b0, 12'h0A8, 0, 32'h0, 1'b0, 1'b1);
        xfer("mid.scr_rd", 1'b0, 12'h0AC, 0, 32'h0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
